uart_echo: RTL and testbench

UART loopback block: receives 8N1 serial bytes on `rxd_i` and retransmits each valid byte unchanged on `txd_o`. It is the serial front end of the UART/ALU datapath and is tested standalone as a byte echo. Bit timing is derived from the system clock by a fixed divider; there are no parallel data ports.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx.sv | 97 +++++++++
 rtl/uart_echo.sv | 126 ++++++++++++
 tb/tb_uart_echo.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and helpers for the echo datapath.
// Both RX and TX FSMs walk the same 8N1 frame phases.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  localparam int unsigned DATA_BITS = 8;

  function automatic int unsigned clks_per_bit(input int unsigned clk, input int unsigned baud);
    return clk / baud;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: two-flop synchronizer, mid-bit sampling FSM, one-cycle rx_valid pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rxd_i,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  logic [1:0]           sync_q;
  logic                 rxd_s;
  logic                 rxd_q;
  uart_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 valid_q, valid_d;

  assign rxd_s    = sync_q[1];
  assign rx_data  = shift_q;
  assign rx_valid = valid_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync_q  <= 2'b11;
      rxd_q   <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rxd_i};
      rxd_q   <= rxd_s;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
    end
  end

  // Edge-triggered start so a line still low after a framing error cannot re-arm.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (rxd_q && !rxd_s) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = rxd_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
          if (bit_q == BIT_LAST) state_d = STOP;
          else bit_d = bit_q + BIT_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          valid_d = rxd_s;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/uart_echo.sv
// UART byte echo: uart_rx feeds a one-byte holding register that drains into an 8N1 transmitter.
module uart_echo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned BAUD_RATE   = 115_200
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rxd_i,
  output logic txd_o
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;

  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 full_q, full_d;
  logic                 take;
  uart_state_e          tx_state_q, tx_state_d;
  logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
  logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 txd_q, txd_d;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .rxd_i    (rxd_i),
    .rx_data  (rx_data),
    .rx_valid (rx_valid)
  );

  assign txd_o = txd_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hold_q     <= '0;
      full_q     <= 1'b0;
      tx_state_q <= IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      hold_q     <= hold_d;
      full_q     <= full_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
    end
  end

  // A byte arriving in the same cycle TX takes the held one refills the register.
  always_comb begin
    take       = (tx_state_q == IDLE) && full_q;
    hold_d     = hold_q;
    full_d     = full_q;
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;

    if (take) full_d = 1'b0;
    if (rx_valid && (!full_q || take)) begin
      hold_d = rx_data;
      full_d = 1'b1;
    end

    case (tx_state_q)
      IDLE: begin
        tx_cnt_d = '0;
        tx_bit_d = '0;
        txd_d    = 1'b1;
        if (full_q) begin
          tx_shift_d = hold_q;
          tx_state_d = START;
          txd_d      = 1'b0;
        end
      end
      START: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = DATA;
          txd_d      = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == BIT_LAST) begin
            tx_state_d = STOP;
            txd_d      = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + BIT_W'(1);
            tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
            txd_d      = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      default: tx_state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_echo.sv
// Bench for uart_echo: serial driver, expected-byte queue and a cycle-exact serial line monitor.
module tb_uart_echo;

  localparam int unsigned CLK_FREQ = 1_600_000;
  localparam int unsigned BAUD     = 100_000;
  localparam int unsigned CPB      = CLK_FREQ / BAUD;
  localparam int unsigned HALF     = CPB / 2;
  localparam int unsigned FRAME    = 10 * CPB;
  localparam int unsigned LAT_MIN  = 9 * CPB + HALF;
  localparam int unsigned LAT_MAX  = LAT_MIN + 8;

  logic clk   = 1'b0;
  logic rst_i = 1'b0;
  logic rxd_i = 1'b1;
  logic txd_o;

  uart_echo #(.CLK_FREQ_HZ(CLK_FREQ), .BAUD_RATE(BAUD)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .rxd_i (rxd_i),
    .txd_o (txd_o)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  byte_v;
    int unsigned t_start;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] echo_log[$];

  bit          mon_active = 1'b0;
  bit          mon_bad;
  int unsigned mon_c;
  logic [9:0]  mon_frame;
  logic [7:0]  mon_dec;
  exp_t        mon_exp;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Expected line: a valid echo is {stop=1, byte, start=0}, each bit held CPB cycles.
  always @(negedge clk) begin
    if (!rst_i) begin
      mon_active = 1'b0;
      exp_q.delete();
      check(txd_o === 1'b1, "txd_in_reset", 32'(txd_o), 32'd1);
    end else if (mon_active) begin
      if (txd_o !== mon_frame[mon_c / CPB] && !mon_bad) begin
        mon_bad = 1'b1;
        errors++;
        $display("FAIL frame_bit: byte 0x%0h cycle %0d got %b expected %b",
                 mon_exp.byte_v, mon_c, txd_o, mon_frame[mon_c / CPB]);
      end
      if ((mon_c % CPB) == HALF && (mon_c / CPB) >= 1 && (mon_c / CPB) <= 8)
        mon_dec[(mon_c / CPB) - 1] = txd_o;
      mon_c++;
      if (mon_c == FRAME) begin
        mon_active = 1'b0;
        checks++;
        echo_log.push_back(mon_dec);
      end
    end else if (txd_o !== 1'b1) begin
      check(exp_q.size() != 0, "unexpected_frame", 32'(exp_q.size()), 32'd1);
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        check((cyc - mon_exp.t_start) >= LAT_MIN && (cyc - mon_exp.t_start) <= LAT_MAX,
              "echo_latency", cyc - mon_exp.t_start, LAT_MIN);
        mon_frame  = {1'b1, mon_exp.byte_v, 1'b0};
        mon_active = 1'b1;
        mon_bad    = 1'b0;
        mon_c      = 1;
        mon_dec    = '0;
      end
    end
  end

  // Entered and left at posedge+1ns so each level lasts exactly n clocks.
  task automatic drive_bit(input logic b, input int unsigned n);
    rxd_i = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    exp_t e;
    e.byte_v  = b;
    e.t_start = cyc;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
    if (stop_bit) exp_q.push_back(e);
    drive_bit(stop_bit, CPB);
  endtask

  task automatic wait_drain(input string name);
    int unsigned n;
    n = 0;
    while ((exp_q.size() != 0 || mon_active) && n < 4 * FRAME) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check(exp_q.size() == 0 && !mon_active, name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int unsigned n;

    // Reset, then a long idle with no frames allowed.
    repeat (2) @(posedge clk);
    #1;
    check(txd_o === 1'b1, "reset_txd", 32'(txd_o), 32'd1);
    rst_i = 1'b1;
    drive_bit(1'b1, 20 * CPB);
    check(txd_o === 1'b1, "idle_after_reset", 32'(txd_o), 32'd1);

    // Isolated bytes.
    send_frame(8'h55, 1'b1); drive_bit(1'b1, FRAME);
    send_frame(8'hAA, 1'b1); drive_bit(1'b1, FRAME);
    send_frame(8'hF0, 1'b1); drive_bit(1'b1, FRAME);
    wait_drain("single_drain");
    check(echo_log.size() == 3, "single_count", 32'(echo_log.size()), 32'd3);
    check(echo_log[0] == 8'h55, "echo_0", 32'(echo_log[0]), 32'h55);
    check(echo_log[1] == 8'hAA, "echo_1", 32'(echo_log[1]), 32'hAA);
    check(echo_log[2] == 8'hF0, "echo_2", 32'(echo_log[2]), 32'hF0);

    // Back-to-back, no idle between frames.
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h3C, 1'b1);
    wait_drain("b2b_drain");
    check(echo_log.size() == 6, "b2b_count", 32'(echo_log.size()), 32'd6);
    check(echo_log[3] == 8'h00, "echo_3", 32'(echo_log[3]), 32'h00);
    check(echo_log[4] == 8'hFF, "echo_4", 32'(echo_log[4]), 32'hFF);
    check(echo_log[5] == 8'h3C, "echo_5", 32'(echo_log[5]), 32'h3C);

    // Framing error: stop bit low, line released, then a good byte.
    send_frame(8'hA5, 1'b0);
    drive_bit(1'b1, 2 * CPB);
    send_frame(8'h12, 1'b1);
    drive_bit(1'b1, FRAME);
    wait_drain("framing_drain");
    check(echo_log.size() == 7, "framing_count", 32'(echo_log.size()), 32'd7);
    check(echo_log[6] == 8'h12, "echo_6", 32'(echo_log[6]), 32'h12);

    // Glitch shorter than half a bit.
    drive_bit(1'b0, 3);
    drive_bit(1'b1, 2 * FRAME);
    check(echo_log.size() == 7, "glitch_count", 32'(echo_log.size()), 32'd7);
    check(txd_o === 1'b1, "glitch_txd", 32'(txd_o), 32'd1);

    // Reset in the middle of echo data bit 3 (0xC3 has bit 3 = 0).
    send_frame(8'hC3, 1'b1);
    n = 0;
    while (!(mon_active && mon_c >= 4 * CPB + HALF) && n < 4 * FRAME) begin
      @(negedge clk);
      n++;
    end
    #2;
    check(mon_active && mon_c >= 4 * CPB + HALF, "reach_bit3", mon_c, 4 * CPB + HALF);
    check(txd_o === 1'b0, "pre_reset_bit3", 32'(txd_o), 32'd0);
    rst_i = 1'b0;
    #1;
    check(txd_o === 1'b1, "async_reset_txd", 32'(txd_o), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b1;
    drive_bit(1'b1, 2 * CPB);
    send_frame(8'h81, 1'b1);
    drive_bit(1'b1, FRAME);
    wait_drain("post_reset_drain");
    check(echo_log.size() == 8, "post_reset_count", 32'(echo_log.size()), 32'd8);
    check(echo_log[7] == 8'h81, "echo_7", 32'(echo_log[7]), 32'h81);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
